// File: rtl/dma_be_req_arbiter_pkg.sv
// dma_be_arb_pkg: shared owner/counter types and the round-robin pick helper for dma_be_req_arbiter
package dma_be_arb_pkg;
  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned MAX_IN_FLIGHT = 4;
  typedef logic [$clog2(NUM_REQ)-1:0] owner_t;
  typedef logic [$clog2(MAX_IN_FLIGHT+1)-1:0] cnt_t;
  function automatic owner_t rr_pick(input logic [NUM_REQ-1:0] valid, input owner_t ptr);
    owner_t pick;
    pick = '0;
    // walk from the farthest offset down so the requester closest to ptr is written last and wins
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (valid[(int'(ptr) + k) % NUM_REQ]) pick = owner_t'((int'(ptr) + k) % NUM_REQ);
    return pick;
  endfunction
endpackage

// File: rtl/dma_be_req_arbiter_fifo.sv
// dma_be_req_arbiter_fifo: in-order owner FIFO (fifo_v3 style) used to route backend completions
//   clk_i/rst_ni  clock, async active-low reset
//   push_i/data_i write an owner id (ignored when full)
//   pop_i/data_o  drop / read the head (pop ignored when empty)
//   full_o/empty_o status from the registered occupancy
module dma_be_req_arbiter_fifo #(
  parameter int unsigned DATA_WIDTH = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0] occ_t;
  localparam occ_t FULL_OCC = occ_t'(DEPTH);
  ptr_t wr_q, wr_d, rd_q, rd_d;
  occ_t occ_q, occ_d;
  logic do_push, do_pop;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  assign full_o  = occ_q == FULL_OCC;
  assign empty_o = occ_q == '0;
  assign data_o  = mem_q[rd_q];
  always_comb begin
    do_push = push_i & ~full_o;
    do_pop  = pop_i & ~empty_o;
    wr_d    = wr_q + ptr_t'(do_push);
    rd_d    = rd_q + ptr_t'(do_pop);
    occ_d   = occ_q + occ_t'(do_push) - occ_t'(do_pop);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      occ_q <= occ_d;
    end
  end
  always_ff @(posedge clk_i) if (do_push) mem_q[wr_q] <= data_i;
endmodule

// File: rtl/dma_be_req_arbiter.sv
// dma_be_req_arbiter: shares one iDMA backend between NumReq frontends and routes completions back in order
//   req_i/req_valid_i/req_ready_o        frontend requests (one lane per frontend)
//   be_req_o/be_valid_o/be_ready_i       backend request channel
//   be_rsp_i/be_rsp_valid_i/be_rsp_ready_o  backend completions
//   rsp_o/rsp_valid_o/rsp_ready_i        completion to owner (valid one-hot)
//   idle_o  per-frontend nothing in flight;  err_o  sticky completion-without-owner
//   Define DMA_BE_ARB_STRICT_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module dma_be_req_arbiter
  import dma_be_arb_pkg::*;
#(
  parameter int unsigned NumReq      = NUM_REQ,
  parameter int unsigned MaxInFlight = MAX_IN_FLIGHT,
  parameter type         idma_req_t  = logic,
  parameter type         idma_rsp_t  = logic
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  idma_req_t         req_i [NumReq],
  input  logic [NumReq-1:0] req_valid_i,
  output logic [NumReq-1:0] req_ready_o,
  output idma_rsp_t         rsp_o,
  output logic [NumReq-1:0] rsp_valid_o,
  input  logic [NumReq-1:0] rsp_ready_i,
  output idma_req_t         be_req_o,
  output logic              be_valid_o,
  input  logic              be_ready_i,
  input  idma_rsp_t         be_rsp_i,
  input  logic              be_rsp_valid_i,
  output logic              be_rsp_ready_o,
  output logic [NumReq-1:0] idle_o,
  output logic              err_o
);
  owner_t gnt, gnt_q, head;
  logic lock_q, lock_d, err_q, err_d, full, empty, hs, pop;
  cnt_t cnt_q [NumReq];
  cnt_t cnt_d [NumReq];
`ifdef DMA_BE_ARB_STRICT_PRIO_EN
  assign gnt = lock_q ? gnt_q : rr_pick(req_valid_i, '0);
`else
  owner_t rr_q, rr_d;
  assign gnt  = lock_q ? gnt_q : rr_pick(req_valid_i, rr_q);
  assign rr_d = hs ? owner_t'((int'(gnt) + 1) % NumReq) : rr_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_q <= '0;
    else rr_q <= rr_d;
  end
`endif
  always_comb begin
    // handshake outputs are qualified by rst_ni so they read 0 while reset is held
    be_valid_o       = rst_ni & ~full & req_valid_i[gnt];
    be_req_o         = req_i[gnt];
    hs               = be_valid_o & be_ready_i;
    req_ready_o      = '0;
    req_ready_o[gnt] = hs;
    lock_d           = be_valid_o & ~be_ready_i;
    rsp_o            = be_rsp_i;
    rsp_valid_o      = '0;
    rsp_valid_o[head] = be_rsp_valid_i & ~empty;
    // with no owner recorded, accept (and drop) any completion so the backend cannot stall
    be_rsp_ready_o   = rst_ni & (empty ? be_rsp_valid_i : rsp_ready_i[head]);
    pop              = be_rsp_valid_i & ~empty & rsp_ready_i[head];
    err_d            = err_q | (be_rsp_valid_i & empty);
    for (int i = 0; i < NumReq; i++) begin
      cnt_d[i]  = cnt_q[i] + cnt_t'(hs && gnt == owner_t'(i)) - cnt_t'(pop && head == owner_t'(i));
      idle_o[i] = cnt_q[i] == '0;
    end
  end
  assign err_o = err_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q <= 1'b0;
      gnt_q  <= '0;
      err_q  <= 1'b0;
      for (int i = 0; i < NumReq; i++) cnt_q[i] <= '0;
    end else begin
      lock_q <= lock_d;
      gnt_q  <= gnt;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
    end
  end
  dma_be_req_arbiter_fifo #(
    .DATA_WIDTH($bits(owner_t)),
    .DEPTH     (MaxInFlight)
  ) u_owner_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (hs),
    .pop_i  (pop),
    .data_i (gnt),
    .data_o (head),
    .full_o (full),
    .empty_o(empty)
  );
endmodule
